// File: rtl/la_wb_master.sv
// Single-outstanding Wishbone classic initiator: one command in, one bus cycle, one response pulse.
// Optional bus-cycle timeout is compiled in with `define LA_WB_MASTER_TIMEOUT_EN.
module la_wb_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [3:0]  cmd_sel_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o
);

    typedef enum logic {IDLE, BUS} state_t;

    state_t state;

    assign cmd_ready_o = (state == IDLE);

`ifdef LA_WB_MASTER_TIMEOUT_EN
    // Counter holds (BUS cycles elapsed - 1); reaching TMO_LAST means this edge ends the last allowed cycle.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt;
    logic       err_q;

    assign rsp_err_o = err_q;
`else
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= 4'h0;
            wbm_adr_o   <= 32'h0;
            wbm_dat_o   <= 32'h0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= 32'h0;
`ifdef LA_WB_MASTER_TIMEOUT_EN
            tmo_cnt     <= 8'h0;
            err_q       <= 1'b0;
`endif
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        state     <= BUS;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= cmd_we_i;
                        wbm_sel_o <= cmd_sel_i;
                        wbm_adr_o <= cmd_adr_i;
                        wbm_dat_o <= cmd_dat_i;
`ifdef LA_WB_MASTER_TIMEOUT_EN
                        tmo_cnt   <= 8'h0;
`endif
                    end
                end
                BUS: begin
                    // Ack is tested first so it wins over a timeout on the same edge.
                    if (wbm_ack_i) begin
                        state       <= IDLE;
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        wbm_we_o    <= 1'b0;
                        wbm_sel_o   <= 4'h0;
                        wbm_adr_o   <= 32'h0;
                        wbm_dat_o   <= 32'h0;
                        rsp_valid_o <= 1'b1;
                        rsp_dat_o   <= wbm_we_o ? 32'h0 : wbm_dat_i;
`ifdef LA_WB_MASTER_TIMEOUT_EN
                        err_q       <= 1'b0;
                        tmo_cnt     <= 8'h0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state       <= IDLE;
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        wbm_we_o    <= 1'b0;
                        wbm_sel_o   <= 4'h0;
                        wbm_adr_o   <= 32'h0;
                        wbm_dat_o   <= 32'h0;
                        rsp_valid_o <= 1'b1;
                        rsp_dat_o   <= 32'h0;
                        err_q       <= 1'b1;
                        tmo_cnt     <= 8'h0;
                    end else begin
                        tmo_cnt     <= tmo_cnt + 8'h1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_la_wb_master.sv
// Directed plus randomized bench for la_wb_master; expected responses come from a
// transaction-level model (ack cycle, timeout limit, read/write) rather than cycle logic.
module tb_la_wb_master;

    localparam int TC = 16;
`ifdef LA_WB_MASTER_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [3:0]  cmd_sel = 4'h0;
    logic [31:0] cmd_adr = 32'h0;
    logic [31:0] cmd_dat = 32'h0;
    logic        wbm_cyc, wbm_stb, wbm_we;
    logic [3:0]  wbm_sel;
    logic [31:0] wbm_adr, wbm_dat;
    logic        wbm_ack = 1'b0;
    logic [31:0] wbm_rdat = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_dat;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rsp = 32'h0;

    always #5 clk = ~clk;

    la_wb_master #(.TIMEOUT_CYCLES(TC)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_sel_i   (cmd_sel),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .wbm_cyc_o   (wbm_cyc),
        .wbm_stb_o   (wbm_stb),
        .wbm_we_o    (wbm_we),
        .wbm_sel_o   (wbm_sel),
        .wbm_adr_o   (wbm_adr),
        .wbm_dat_o   (wbm_dat),
        .wbm_ack_i   (wbm_ack),
        .wbm_dat_i   (wbm_rdat),
        .rsp_valid_o (rsp_valid),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts at a falling edge with the block idle; returns at the falling edge where
    // the response pulse should be visible, so the next call can issue back-to-back.
    task automatic txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                       input logic [31:0] dat, input int ack_cycle,
                       input logic [31:0] rdata, input bit inject);
        int          stb_cnt;
        int          exp_cnt;
        bit          acked;
        bit          fields_ok;
        bit          done;
        logic [31:0] exp_dat;
        acked   = !(TMO && (ack_cycle == 0 || ack_cycle > TC));
        exp_cnt = acked ? ack_cycle : TC;
        exp_dat = (acked && !we) ? rdata : 32'h0;

        check("ready_at_issue", 32'(cmd_ready), 32'h1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_sel   = sel;
        cmd_adr   = adr;
        cmd_dat   = dat;
        stb_cnt   = 0;
        fields_ok = 1'b1;
        done      = 1'b0;
        for (int k = 1; k <= 300 && !done; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cmd_valid = 1'b0;
                cmd_adr   = $urandom;
                cmd_dat   = $urandom;
                check("rsp_single_pulse", 32'(rsp_valid), 32'h0);
                check("rsp_dat_held", rsp_dat, last_rsp);
            end
            if (wbm_stb) begin
                stb_cnt++;
                if (!(wbm_cyc && wbm_we == we && wbm_sel == sel && wbm_adr == adr &&
                      wbm_dat == dat && !rsp_valid && !cmd_ready))
                    fields_ok = 1'b0;
                wbm_ack  = (k == ack_cycle);
                wbm_rdat = wbm_ack ? rdata : $urandom;
                if (inject && k == 2) begin
                    cmd_valid = 1'b1;
                    cmd_adr   = 32'h1;
                    cmd_we    = ~we;
                    cmd_sel   = ~sel;
                end
            end else begin
                done    = 1'b1;
                wbm_ack = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        wbm_ack   = 1'b0;
        check("done_in_budget", 32'(done), 32'h1);
        check("stb_cycles", 32'(stb_cnt), 32'(exp_cnt));
        check("fields_stable", 32'(fields_ok), 32'h1);
        check("rsp_valid", 32'(rsp_valid), 32'h1);
        check("rsp_dat", rsp_dat, exp_dat);
        check("rsp_err", 32'(rsp_err), 32'(!acked));
        check("ready_with_rsp", 32'(cmd_ready), 32'h1);
        check("idle_ctrl", {25'h0, wbm_cyc, wbm_stb, wbm_we, wbm_sel}, 32'h0);
        check("idle_adr_dat", wbm_adr | wbm_dat, 32'h0);
        last_rsp = exp_dat;
    endtask

    initial begin
        int gap;
        // Reset state
        #12;
        check("rst_ctrl", {25'h0, wbm_cyc, wbm_stb, wbm_we, wbm_sel}, 32'h0);
        check("rst_adr_dat", wbm_adr | wbm_dat, 32'h0);
        check("rst_rsp", {30'h0, rsp_valid, rsp_err}, 32'h0);
        check("rst_rsp_dat", rsp_dat, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(cmd_ready), 32'h1);

        // Write with ack in the third bus cycle, then a one-cycle read issued back-to-back
        txn(1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_1234, 3, $urandom, 1'b0);
        txn(1'b0, 4'hF, 32'h3000_0008, $urandom, 1, 32'hCAFE_F00D, 1'b0);
        // Command presented while busy must be ignored
        txn(1'b0, 4'h3, 32'h3000_0020, $urandom, 4, 32'h1234_5678, 1'b1);
        // Silent responder (timeout build) or long wait (no-timeout build), then ack exactly at the limit
        txn(1'b0, 4'hF, 32'h3000_0030, $urandom, TMO ? 0 : 40, 32'hDEAD_BEEF, 1'b0);
        txn(1'b0, 4'hF, 32'h3000_0034, $urandom, TC, 32'h0BAD_CAFE, 1'b0);
        txn(1'b1, 4'hC, 32'h3000_0038, 32'h5555_AAAA, TC + 1, 32'h7777_7777, 1'b0);

        // Reset in the second bus cycle aborts without a response
        check("ready_pre_abort", 32'(cmd_ready), 32'h1);
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_sel   = 4'hF;
        cmd_adr   = 32'h3000_0010;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("stb_before_abort", 32'(wbm_stb), 32'h1);
        rst = 1'b1;
        #1;
        check("abort_cyc_stb", {30'h0, wbm_cyc, wbm_stb}, 32'h0);
        check("abort_adr", wbm_adr, 32'h0);
        check("abort_rsp_dat", rsp_dat, 32'h0);
        @(negedge clk);
        check("abort_no_rsp", 32'(rsp_valid), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_no_rsp_after", 32'(rsp_valid), 32'h0);
        check("ready_after_abort", 32'(cmd_ready), 32'h1);
        last_rsp = 32'h0;
        txn(1'b0, 4'hF, 32'h3000_000C, $urandom, 2, 32'h600D_0001, 1'b0);

        // Randomized traffic with occasional idle gaps
        for (int i = 0; i < 24; i++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) @(negedge clk);
            txn(1'($urandom), 4'($urandom), $urandom, $urandom,
                int'($urandom_range(1, 24)), $urandom, 1'($urandom));
        end
        @(negedge clk);
        check("final_no_rsp", 32'(rsp_valid), 32'h0);
        check("final_rsp_held", rsp_dat, last_rsp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/la_wb_master.md
LA_WB_MASTER -- requirements
Module: la_wb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum bus cycles to wait for wbm_ack_i (range 2..255).
REQ-002 SHALL have port wb_clk_i, input, 1, single clock; all logic rising-edge.
REQ-003 SHALL have port wb_rst_i, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port cmd_valid_i, input, 1, command request.
REQ-005 SHALL have port cmd_ready_o, output, 1, block idle and able to accept a command.
REQ-006 SHALL have port cmd_we_i, input, 1, 1 = write, 0 = read.
REQ-007 SHALL have port cmd_sel_i, input, 4, byte selects.
REQ-008 SHALL have ports cmd_adr_i and cmd_dat_i, input, 32 each, address and write data.
REQ-009 SHALL have ports wbm_cyc_o, wbm_stb_o and wbm_we_o, output, 1 each, Wishbone classic initiator controls.
REQ-010 SHALL have port wbm_sel_o, output, 4, byte selects to the bus.
REQ-011 SHALL have ports wbm_adr_o and wbm_dat_o, output, 32 each, address and write data to the bus.
REQ-012 SHALL have port wbm_ack_i, input, 1, responder acknowledge.
REQ-013 SHALL have port wbm_dat_i, input, 32, responder read data.
REQ-014 SHALL have port rsp_valid_o, output, 1, one-cycle completion pulse.
REQ-015 SHALL have port rsp_dat_o, output, 32, read data of the completed transaction.
REQ-016 SHALL have port rsp_err_o, output, 1, completed transaction timed out.

Function
REQ-017 SHALL implement two states: IDLE and BUS; cmd_ready_o = (state == IDLE).
REQ-018 SHALL, on a rising edge with cmd_valid_i & cmd_ready_o, register we/sel/adr/dat onto the wbm_* outputs and enter BUS; wbm_cyc_o/wbm_stb_o SHALL be high from the next cycle.
REQ-019 SHALL ignore cmd_valid_i while in BUS (no queueing, no corruption of registered fields).
REQ-020 SHALL hold wbm_* outputs stable for the whole of BUS.
REQ-021 SHALL, on a rising edge in BUS with wbm_ack_i high, deassert cyc/stb and return to IDLE; rsp_valid_o SHALL be high exactly the following cycle.
REQ-022 SHALL set rsp_dat_o on completion to the wbm_dat_i sampled with ack for reads, and to 32'h0 for writes; rsp_err_o = 0.
REQ-023 SHALL hold rsp_dat_o and rsp_err_o until the next completion.
REQ-024 SHALL allow back-to-back operation: a command may be accepted in the same cycle rsp_valid_o is high, giving a minimum of 2 clocks per transaction (ack in first BUS cycle).
REQ-025 SHALL drive wbm_we_o, wbm_sel_o, wbm_adr_o and wbm_dat_o to 0 in IDLE.

Reset
REQ-026 SHALL, on wb_rst_i asserted, immediately force state = IDLE, all wbm_* outputs = 0, rsp_valid_o = 0, rsp_dat_o = 0, rsp_err_o = 0, and the timeout counter = 0.
REQ-027 SHALL abort an in-flight transaction on reset with no rsp_valid_o pulse; cmd_ready_o SHALL be 1 from the first edge after deassertion.

Configuration
REQ-028 SHALL, with LA_WB_MASTER_TIMEOUT_EN defined, count BUS cycles without ack and terminate at the edge ending the TIMEOUT_CYCLES-th BUS cycle: cyc/stb low, rsp_valid_o pulse next cycle, rsp_err_o = 1, rsp_dat_o = 32'h0.
REQ-029 SHALL give ack priority over timeout when both occur on the same edge (normal completion, rsp_err_o = 0).
REQ-030 SHALL, with LA_WB_MASTER_TIMEOUT_EN undefined, contain no counter, wait for ack indefinitely, and tie rsp_err_o to 0.

Verification
REQ-031 SHALL verify a write: adr=0x3000_0004, dat=0xA5A5_1234, sel=0xF, ack after 3 BUS cycles -> cyc/stb high 3 cycles, we=1, single rsp_valid_o pulse, rsp_dat_o=0, rsp_err_o=0.
REQ-032 SHALL verify a read: adr=0x3000_0008, responder returns 0xCAFE_F00D with ack in the first BUS cycle -> rsp_dat_o=0xCAFE_F00D, total 2 clocks, cmd_ready_o high with rsp_valid_o.
REQ-033 SHALL verify busy rejection: a second cmd_valid_i (adr=0x1) asserted mid-transaction -> wbm_adr_o unchanged, exactly one response.
REQ-034 SHALL verify timeout with TIMEOUT_EN defined and TIMEOUT_CYCLES=16, responder never acks -> stb high exactly 16 cycles, rsp_err_o=1, rsp_dat_o=0; ack on cycle 16 -> rsp_err_o=0.
REQ-035 SHALL verify reset mid-BUS: wb_rst_i asserted on BUS cycle 2 -> cyc/stb low asynchronously, no rsp_valid_o, a new read succeeds after deassertion.
